// File: rtl/demultiplexer_if.sv
// Handshake bundle between a word initiator and the demultiplexer, plus the
// per-channel output side. The master drives words in; the slave routes them.
interface demultiplexer_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic [SELW-1:0]           in_sel;
  logic [CHANNELS*WIDTH-1:0] out_bus;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic                      err;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_bus, out_valid, err
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_bus, out_valid, err
  );
endinterface

// File: rtl/demultiplexer.sv
// Single-entry routing register: accepts one word with a channel index and
// presents it on that channel's slice until the channel's consumer takes it.
module demultiplexer #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic            clock,
  input  logic            reset,
  demultiplexer_if.slave  bus_if
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             err_q, err_d;

  logic accept;
  logic drain;
  logic sel_ok;

  // Extra bit keeps the range check meaningful when CHANNELS is a power of two.
  assign sel_ok = ({1'b0, bus_if.in_sel} < (SELW+1)'(CHANNELS));
  assign drain  = full_q && bus_if.out_ready[sel_q];
  assign bus_if.in_ready = !full_q || bus_if.out_ready[sel_q];
  assign accept = bus_if.in_valid && bus_if.in_ready;
  assign bus_if.err = err_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    sel_d  = sel_q;
    err_d  = accept && !sel_ok;
    if (accept && sel_ok) begin
      full_d = 1'b1;
      data_d = bus_if.in_data;
      sel_d  = bus_if.in_sel;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
    end
  end

  // Channel 0 occupies the most significant slice of the bus.
  always_comb begin
    bus_if.out_bus   = '0;
    bus_if.out_valid = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (full_q && sel_q == SELW'(k)) begin
        bus_if.out_valid[k] = 1'b1;
        bus_if.out_bus[(CHANNELS-1-k)*WIDTH +: WIDTH] = data_q;
      end
    end
  end
endmodule

// File: tb/tb_demultiplexer.sv
// Directed checks of the demultiplexer: a 2-channel and a 3-channel instance.
module tb_demultiplexer;
  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  demultiplexer_if #(.WIDTH(32), .CHANNELS(2)) a_if ();
  demultiplexer_if #(.WIDTH(32), .CHANNELS(3)) b_if ();

  demultiplexer #(.WIDTH(32), .CHANNELS(2)) dut_a (.clock(clock), .reset(reset), .bus_if(a_if.slave));
  demultiplexer #(.WIDTH(32), .CHANNELS(3)) dut_b (.clock(clock), .reset(reset), .bus_if(b_if.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_sel = '0; a_if.out_ready = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_sel = '0; b_if.out_ready = '0;
    #2;
    chk("rst_valid", 128'(a_if.out_valid), 128'h0);
    chk("rst_bus",   128'(a_if.out_bus),   128'h0);
    chk("rst_ready", 128'(a_if.in_ready),  128'h1);
    chk("rst_err",   128'(a_if.err),       128'h0);

    // First word right after reset release, to channel 1
    @(negedge clock);
    reset = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_sel = 1'b1; a_if.in_data = 32'hDEADBEEF; a_if.out_ready = 2'b10;
    tick();
    a_if.in_valid = 1'b0;
    chk("first_valid", 128'(a_if.out_valid), 128'h2);
    chk("first_bus",   128'(a_if.out_bus),   128'h00000000_DEADBEEF);
    tick();
    chk("first_drain", 128'(a_if.out_valid), 128'h0);
    chk("first_bus0",  128'(a_if.out_bus),   128'h0);

    // Backpressure on channel 0; a competing word must be refused
    a_if.out_ready = 2'b00;
    a_if.in_valid = 1'b1; a_if.in_sel = 1'b0; a_if.in_data = 32'h11111111;
    tick();
    a_if.in_sel = 1'b1; a_if.in_data = 32'h99999999;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 128'(a_if.in_ready),  128'h0);
      chk("bp_valid", 128'(a_if.out_valid), 128'h1);
      chk("bp_bus",   128'(a_if.out_bus),   128'h11111111_00000000);
      tick();
    end
    a_if.in_valid = 1'b0;
    a_if.out_ready = 2'b01;
    #1;
    chk("bp_ready_rel", 128'(a_if.in_ready), 128'h1);
    tick();
    chk("bp_drain", 128'(a_if.out_valid), 128'h0);

    // Ready on the non-selected channel must not drain
    a_if.out_ready = 2'b01;
    a_if.in_valid = 1'b1; a_if.in_sel = 1'b1; a_if.in_data = 32'h22222222;
    tick();
    a_if.in_valid = 1'b0;
    chk("nsel_valid", 128'(a_if.out_valid), 128'h2);
    chk("nsel_ready", 128'(a_if.in_ready),  128'h0);
    tick();
    chk("nsel_hold",  128'(a_if.out_valid), 128'h2);
    chk("nsel_bus",   128'(a_if.out_bus),   128'h00000000_22222222);
    a_if.out_ready = 2'b10;
    tick();
    chk("nsel_drain", 128'(a_if.out_valid), 128'h0);

    // Streaming: one word per cycle alternating channels
    a_if.out_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_data  = 32'(i + 1);
      a_if.in_sel   = 1'(i % 2);
      #1;
      chk("str_ready", 128'(a_if.in_ready), 128'h1);
      tick();
      chk("str_valid", 128'(a_if.out_valid), (i % 2 == 0) ? 128'h1 : 128'h2);
      chk("str_bus",   128'(a_if.out_bus),
          (i % 2 == 0) ? {64'h0, 32'(i + 1), 32'h0} : {96'h0, 32'(i + 1)});
    end
    a_if.in_valid = 1'b0;
    tick();
    chk("str_empty", 128'(a_if.out_valid), 128'h0);

    // Out-of-range select on the 3-channel instance
    b_if.in_valid = 1'b1; b_if.in_sel = 2'd3; b_if.in_data = 32'h55555555;
    #1;
    chk("oor_ready", 128'(b_if.in_ready), 128'h1);
    tick();
    b_if.in_valid = 1'b0;
    chk("oor_err",   128'(b_if.err),       128'h1);
    chk("oor_valid", 128'(b_if.out_valid), 128'h0);
    chk("oor_rdy2",  128'(b_if.in_ready),  128'h1);
    tick();
    chk("oor_err_end", 128'(b_if.err), 128'h0);

    // Drain of channel 2 coinciding with an out-of-range accept
    b_if.out_ready = 3'b000;
    b_if.in_valid = 1'b1; b_if.in_sel = 2'd2; b_if.in_data = 32'h0A0B0C0D;
    tick();
    chk("b_ch2_valid", 128'(b_if.out_valid), 128'h4);
    chk("b_ch2_bus",   128'(b_if.out_bus),   128'h0A0B0C0D);
    b_if.in_sel = 2'd3; b_if.out_ready = 3'b100;
    tick();
    b_if.in_valid = 1'b0;
    chk("b_mix_valid", 128'(b_if.out_valid), 128'h0);
    chk("b_mix_err",   128'(b_if.err),       128'h1);

    // Asynchronous reset while a word is held
    a_if.out_ready = 2'b00;
    a_if.in_valid = 1'b1; a_if.in_sel = 1'b0; a_if.in_data = 32'hA5A5A5A5;
    tick();
    a_if.in_valid = 1'b0;
    chk("hold_valid", 128'(a_if.out_valid), 128'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 128'(a_if.out_valid), 128'h0);
    chk("arst_bus",   128'(a_if.out_bus),   128'h0);
    chk("arst_ready", 128'(a_if.in_ready),  128'h1);
    @(negedge clock);
    reset = 1'b0;
    a_if.out_ready = 2'b11;
    tick();
    chk("arst_gone", 128'(a_if.out_valid), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/demultiplexer.md
DEMULTIPLEXER -- requirements
Module: demultiplexer

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one data word.
REQ-002 Parameter CHANNELS, default 2, number of output channels; SHALL be >= 2.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  initiator presents a word.
REQ-006 Port in_ready  output  1  block accepts the word this cycle.
REQ-007 Port in_data  input  WIDTH  word to route.
REQ-008 Port in_sel  input  $clog2(CHANNELS)  destination channel index.
REQ-009 Port out_bus  output  CHANNELS*WIDTH  packed channel words; channel k at bits [((CHANNELS-1-k)*WIDTH) +: WIDTH], i.e. channel 0 in the most significant slice.
REQ-010 Port out_valid  output  CHANNELS  bit k: channel k holds a valid word.
REQ-011 Port out_ready  input  CHANNELS  bit k: channel k consumer accepts.
REQ-012 Port err  output  1  one-cycle pulse: a word with out-of-range in_sel was dropped.

Function
REQ-013 Block SHALL contain one holding register: full flag, data_q (WIDTH), sel_q.
REQ-014 Input handshake: accept occurs when in_valid && in_ready at a rising edge.
REQ-015 in_ready SHALL equal !full || out_ready[sel_q] (combinational; full throughput of 1 word/cycle).
REQ-016 Output handshake: drain occurs when full && out_ready[sel_q] at a rising edge.
REQ-017 out_valid[k] SHALL be 1 iff full && sel_q == k; at most one bit set.
REQ-018 Slice sel_q of out_bus SHALL carry data_q while full; every other slice, and all slices while !full, SHALL be zero.
REQ-019 Latency: word accepted at edge N SHALL appear on out_valid/out_bus in the cycle after edge N.
REQ-020 Accept with in_sel < CHANNELS SHALL load data_q <= in_data, sel_q <= in_sel, full <= 1.
REQ-021 Accept with in_sel >= CHANNELS SHALL not load the register; err SHALL be 1 for exactly the following cycle.
REQ-022 Drain without valid load SHALL set full <= 0; data_q, sel_q hold value.
REQ-023 Simultaneous drain and valid load SHALL replace contents, full stays 1, no bubble.
REQ-024 Simultaneous drain and invalid accept SHALL clear full and pulse err.
REQ-025 While full && !out_ready[sel_q], data_q, sel_q, out_valid, out_bus SHALL stay stable; in_ready SHALL be 0.
REQ-026 out_ready bits of non-selected channels SHALL have no effect.
REQ-027 in_data/in_sel SHALL be ignored when in_valid is 0.

Reset
REQ-028 reset assertion SHALL immediately (asynchronously) force full=0, data_q=0, sel_q=0, err=0; hence out_valid=0, out_bus=0, in_ready=1.
REQ-029 Reset mid-operation SHALL discard any held word; no drain is reported for it.
REQ-030 First accept SHALL be possible at the first rising edge after reset deasserts.

Verification
REQ-031 WIDTH=32, CHANNELS=2: after reset, in_valid=1, in_sel=1, in_data=0xDEADBEEF, out_ready=2'b10 -> next cycle out_valid=2'b10, out_bus=64'h00000000_DEADBEEF; drained following edge.
REQ-032 Backpressure: load 0x11111111 to channel 0, out_ready=0 for 3 cycles -> in_ready=0, out_bus=64'h11111111_00000000 constant 3 cycles; out_ready[0]=1 -> drained.
REQ-033 Streaming: 4 words 1,2,3,4 to channels 0,1,0,1, all out_ready=1 -> one word per cycle on out_valid 2'b01,2'b10,2'b01,2'b10, no bubbles, in_ready constantly 1.
REQ-034 CHANNELS=3: in_sel=3 accepted -> err=1 one cycle, out_valid stays 0, in_ready=1.
REQ-035 Reset mid-hold: word 0xA5A5A5A5 held with out_ready=0, assert reset between edges -> out_valid=0, out_bus=0, in_ready=1 immediately, before next edge.
REQ-036 Non-selected ready: held word on channel 1, out_ready=2'b01 -> word not drained, out_valid remains 2'b10.
